// File: rtl/db_tx_engine.sv
// db_tx_engine: sends a single doorbell request beat on the HELLO ireq stream,
// then waits for the matching iresp (by transaction ID) or a timeout.
// Optional macro DB_TX_RETRY_EN: on timeout, resend the same tid/info up to
// C_MAX_RETRY times before reporting an error. Without it, the first timeout
// reports an error.
module db_tx_engine #(
    parameter logic [15:0] C_SRIO_DEV_ID  = 16'hF201,
    parameter logic [15:0] C_SRIO_DEST_ID = 16'h7801,
    parameter logic [1:0]  C_PRIO         = 2'b01,
    parameter logic [31:0] C_TIMEOUT      = 32'd1000000,
    parameter int unsigned C_MAX_RETRY    = 3
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        db_req_valid,
    output logic        db_req_ready,
    input  logic [15:0] db_req_info,
    output logic        db_done,
    output logic        db_err,
    output logic        db_busy,

    output logic        m_axis_ireq_tvalid,
    input  logic        m_axis_ireq_tready,
    output logic [63:0] m_axis_ireq_tdata,
    output logic [7:0]  m_axis_ireq_tkeep,
    output logic        m_axis_ireq_tlast,
    output logic [31:0] m_axis_ireq_tuser,

    input  logic        s_axis_iresp_tvalid,
    output logic        s_axis_iresp_tready,
    input  logic [63:0] s_axis_iresp_tdata,
    input  logic [7:0]  s_axis_iresp_tkeep,
    input  logic        s_axis_iresp_tlast,
    input  logic [31:0] s_axis_iresp_tuser
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    localparam logic [31:0] TIMEOUT_LAST = C_TIMEOUT - 32'd1;
    localparam logic [7:0]  TYPE_DONE    = 8'hD0;

    state_t      state;
    logic [7:0]  tid;
    logic [31:0] wait_cnt;

`ifdef DB_TX_RETRY_EN
    localparam int unsigned RETRY_W = (C_MAX_RETRY > 0) ? $clog2(C_MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(C_MAX_RETRY);
    logic [RETRY_W-1:0] retry_cnt;
`endif

    logic resp_match;
    logic timeout_hit;
    logic unused_iresp;

    assign resp_match  = s_axis_iresp_tvalid && s_axis_iresp_tready &&
                         (s_axis_iresp_tdata[63:56] == tid);
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    // Response fields that carry no meaning for a doorbell are ignored.
    assign unused_iresp = ^{s_axis_iresp_tdata[47:0], s_axis_iresp_tkeep,
                            s_axis_iresp_tlast, s_axis_iresp_tuser};

    // Request FSM: all outputs are registered and updated alongside the state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state               <= IDLE;
            tid                 <= '0;
            wait_cnt            <= '0;
`ifdef DB_TX_RETRY_EN
            retry_cnt           <= '0;
`endif
            db_req_ready        <= 1'b0;
            db_done             <= 1'b0;
            db_err              <= 1'b0;
            db_busy             <= 1'b0;
            m_axis_ireq_tvalid  <= 1'b0;
            m_axis_ireq_tdata   <= '0;
            m_axis_ireq_tkeep   <= '0;
            m_axis_ireq_tlast   <= 1'b0;
            m_axis_ireq_tuser   <= '0;
            s_axis_iresp_tready <= 1'b0;
        end else begin
            db_done             <= 1'b0;
            db_err              <= 1'b0;
            s_axis_iresp_tready <= 1'b1;

            case (state)
                IDLE: begin
                    db_req_ready <= 1'b1;
                    db_busy      <= 1'b0;
                    if (db_req_valid && db_req_ready) begin
                        m_axis_ireq_tvalid <= 1'b1;
                        m_axis_ireq_tdata  <= {tid, 8'hA0, 1'b0, C_PRIO, 1'b0, 12'h000,
                                               db_req_info, 16'h0000};
                        m_axis_ireq_tkeep  <= 8'hFF;
                        m_axis_ireq_tlast  <= 1'b1;
                        m_axis_ireq_tuser  <= {C_SRIO_DEV_ID, C_SRIO_DEST_ID};
`ifdef DB_TX_RETRY_EN
                        retry_cnt          <= '0;
`endif
                        db_req_ready       <= 1'b0;
                        db_busy            <= 1'b1;
                        state              <= SEND;
                    end
                end

                SEND: begin
                    if (m_axis_ireq_tready) begin
                        m_axis_ireq_tvalid <= 1'b0;
                        wait_cnt           <= '0;
                        state              <= WAIT;
                    end
                end

                WAIT: begin
                    // A matching response wins over a timeout landing in the same cycle.
                    if (resp_match) begin
                        if (s_axis_iresp_tdata[55:48] == TYPE_DONE) begin
                            db_done <= 1'b1;
                        end else begin
                            db_err  <= 1'b1;
                        end
                        tid          <= tid + 8'd1;
                        db_req_ready <= 1'b1;
                        db_busy      <= 1'b0;
                        state        <= IDLE;
                    end else if (timeout_hit) begin
`ifdef DB_TX_RETRY_EN
                        if (retry_cnt < RETRY_LAST) begin
                            // The held ireq beat still carries the original tid/info.
                            retry_cnt          <= retry_cnt + RETRY_W'(1);
                            m_axis_ireq_tvalid <= 1'b1;
                            state              <= SEND;
                        end else begin
                            db_err       <= 1'b1;
                            tid          <= tid + 8'd1;
                            db_req_ready <= 1'b1;
                            db_busy      <= 1'b0;
                            state        <= IDLE;
                        end
`else
                        db_err       <= 1'b1;
                        tid          <= tid + 8'd1;
                        db_req_ready <= 1'b1;
                        db_busy      <= 1'b0;
                        state        <= IDLE;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_db_tx_engine.sv
// tb_db_tx_engine: randomized scoreboard bench for db_tx_engine.
// Honours DB_TX_RETRY_EN to predict the number of beats sent on timeout.
module tb_db_tx_engine;

    localparam logic [15:0] DEV  = 16'hF201;
    localparam logic [15:0] DST  = 16'h7801;
    localparam logic [1:0]  PRIO = 2'b01;
    localparam int          MAXR = 3;
`ifdef DB_TX_RETRY_EN
    localparam int BEATS_ON_TIMEOUT = MAXR + 1;
`else
    localparam int BEATS_ON_TIMEOUT = 1;
`endif
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        db_req_valid = 1'b0;
    logic        db_req_ready;
    logic [15:0] db_req_info = '0;
    logic        db_done, db_err, db_busy;
    logic        m_axis_ireq_tvalid;
    logic        m_axis_ireq_tready = 1'b1;
    logic [63:0] m_axis_ireq_tdata;
    logic [7:0]  m_axis_ireq_tkeep;
    logic        m_axis_ireq_tlast;
    logic [31:0] m_axis_ireq_tuser;
    logic        s_axis_iresp_tvalid = 1'b0;
    logic        s_axis_iresp_tready;
    logic [63:0] s_axis_iresp_tdata = '0;
    logic [7:0]  s_axis_iresp_tkeep = 8'hFF;
    logic        s_axis_iresp_tlast = 1'b1;
    logic [31:0] s_axis_iresp_tuser = '0;

    db_tx_engine #(
        .C_SRIO_DEV_ID (DEV),
        .C_SRIO_DEST_ID(DST),
        .C_PRIO        (PRIO),
        .C_TIMEOUT     (32'd16),
        .C_MAX_RETRY   (MAXR)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .db_req_valid       (db_req_valid),
        .db_req_ready       (db_req_ready),
        .db_req_info        (db_req_info),
        .db_done            (db_done),
        .db_err             (db_err),
        .db_busy            (db_busy),
        .m_axis_ireq_tvalid (m_axis_ireq_tvalid),
        .m_axis_ireq_tready (m_axis_ireq_tready),
        .m_axis_ireq_tdata  (m_axis_ireq_tdata),
        .m_axis_ireq_tkeep  (m_axis_ireq_tkeep),
        .m_axis_ireq_tlast  (m_axis_ireq_tlast),
        .m_axis_ireq_tuser  (m_axis_ireq_tuser),
        .s_axis_iresp_tvalid(s_axis_iresp_tvalid),
        .s_axis_iresp_tready(s_axis_iresp_tready),
        .s_axis_iresp_tdata (s_axis_iresp_tdata),
        .s_axis_iresp_tkeep (s_axis_iresp_tkeep),
        .s_axis_iresp_tlast (s_axis_iresp_tlast),
        .s_axis_iresp_tuser (s_axis_iresp_tuser)
    );

    always #5 aclk = ~aclk;

    // Scoreboard state
    logic [63:0] exp_beat_q[$];
    int          exp_stall_q[$];
    int          exp_evt_q[$];
    int          total = 0;
    int          passed = 0;
    int          beats_seen = 0;
    int          events_seen = 0;
    int          stall_cnt = 0;
    int          mon_ev;
    logic [63:0] first_beat = '0;
    logic [7:0]  tid_m = 8'h00;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference formula for the doorbell request word.
    function automatic logic [63:0] exp_tdata(input logic [7:0] t, input logic [15:0] inf);
        return {t, 8'hA0, 1'b0, PRIO, 1'b0, 12'h000, inf, 16'h0000};
    endfunction

    // Monitor: compares every ireq beat and every done/err pulse against the queues.
    always @(negedge aclk) begin
        if (areset) begin
            stall_cnt = 0;
        end else begin
            if (m_axis_ireq_tvalid) begin
                check64("ireq_beat_pending", 64'(exp_beat_q.size() != 0), 64'd1);
                if (exp_beat_q.size() != 0) begin
                    check64("ireq_tdata", m_axis_ireq_tdata, exp_beat_q[0]);
                    if (m_axis_ireq_tready) begin
                        check64("ireq_tkeep", 64'(m_axis_ireq_tkeep), 64'hFF);
                        check64("ireq_tlast", 64'(m_axis_ireq_tlast), 64'd1);
                        check64("ireq_tuser", 64'(m_axis_ireq_tuser), 64'({DEV, DST}));
                        check64("ireq_stall_cycles", 64'(stall_cnt), 64'(exp_stall_q[0]));
                        if (beats_seen == 0) first_beat = m_axis_ireq_tdata;
                        void'(exp_beat_q.pop_front());
                        void'(exp_stall_q.pop_front());
                        beats_seen++;
                        stall_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (db_done || db_err) begin
                check64("done_err_exclusive", 64'(db_done & db_err), 64'd0);
                check64("event_pending", 64'(exp_evt_q.size() != 0), 64'd1);
                if (exp_evt_q.size() != 0) begin
                    mon_ev = exp_evt_q.pop_front();
                    check64("event_kind", 64'(db_done ? EV_DONE : EV_ERR), 64'(mon_ev));
                end
                events_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!db_req_ready && n < 1000) begin tick(); n++; end
        if (n >= 1000) check64("wait_req_ready", 64'(db_req_ready), 64'd1);
    endtask

    task automatic wait_beat(input int b0);
        int n = 0;
        while (beats_seen == b0 && n < 1000) begin tick(); n++; end
        if (n >= 1000) check64("wait_ireq_beat", 64'(beats_seen), 64'(b0 + 1));
    endtask

    task automatic wait_event(input int e0);
        int n = 0;
        while (events_seen == e0 && n < 2000) begin tick(); n++; end
        if (n >= 2000) check64("wait_done_err", 64'(events_seen), 64'(e0 + 1));
    endtask

    task automatic send_resp(input logic [7:0] t, input logic [7:0] ty);
        s_axis_iresp_tvalid = 1'b1;
        s_axis_iresp_tdata  = {t, ty, 48'h0000_0000_0000};
        tick();
        s_axis_iresp_tvalid = 1'b0;
    endtask

    // One full request: queue expectations, drive request, optional response.
    task automatic do_req(input logic [15:0] info, input bit no_resp, input logic [7:0] rtype,
                          input int delay, input bit stray_en, input logic [7:0] stray_tid,
                          input int stall);
        int b0, e0, nbeats;
        wait_ready();
        b0 = beats_seen;
        e0 = events_seen;
        nbeats = no_resp ? BEATS_ON_TIMEOUT : 1;
        for (int i = 0; i < nbeats; i++) begin
            exp_beat_q.push_back(exp_tdata(tid_m, info));
            exp_stall_q.push_back(i == 0 ? stall : 0);
        end
        exp_evt_q.push_back((!no_resp && rtype == 8'hD0) ? EV_DONE : EV_ERR);
        m_axis_ireq_tready = (stall == 0);
        db_req_valid = 1'b1;
        db_req_info  = info;
        tick();
        db_req_valid = 1'b0;
        check64("busy_after_accept", 64'(db_busy), 64'd1);
        check64("ready_low_after_accept", 64'(db_req_ready), 64'd0);
        repeat (stall) tick();
        m_axis_ireq_tready = 1'b1;
        if (!no_resp) begin
            wait_beat(b0);
            repeat (delay) tick();
            if (stray_en) send_resp(stray_tid, 8'hD0);
            send_resp(tid_m, rtype);
        end
        wait_event(e0);
        tick();
        check64("ready_after_complete", 64'(db_req_ready), 64'd1);
        check64("busy_after_complete", 64'(db_busy), 64'd0);
        tid_m = tid_m + 8'd1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, e0;
        logic [7:0] rt;

        // Reset values
        repeat (3) tick();
        check64("rst_req_ready", 64'(db_req_ready), 64'd0);
        check64("rst_busy", 64'(db_busy), 64'd0);
        check64("rst_done_err", 64'({db_done, db_err}), 64'd0);
        check64("rst_ireq_tvalid", 64'(m_axis_ireq_tvalid), 64'd0);
        check64("rst_ireq_tdata", m_axis_ireq_tdata, 64'd0);
        check64("rst_ireq_side", 64'({m_axis_ireq_tkeep, m_axis_ireq_tlast, m_axis_ireq_tuser}), 64'd0);
        check64("rst_iresp_tready", 64'(s_axis_iresp_tready), 64'd0);
        areset = 1'b0;
        tick();
        check64("post_rst_req_ready", 64'(db_req_ready), 64'd1);
        check64("post_rst_iresp_tready", 64'(s_axis_iresp_tready), 64'd1);

        // Basic doorbell, response after 5 cycles
        do_req(16'h1234, 1'b0, 8'hD0, 5, 1'b0, 8'h00, 0);
        check64("first_ireq_word", first_beat, 64'h00A0_2000_1234_0000);
        // Back-pressure: tready low for 4 cycles
        do_req(16'hCAFE, 1'b0, 8'hD0, 2, 1'b0, 8'h00, 4);
        // Timeout (with or without retries)
        do_req(16'h5A5A, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1);
        // Error response type
        do_req(16'h0D07, 1'b0, 8'hD7, 3, 1'b0, 8'h00, 1);

        // Randomized traffic, long enough to wrap tid
        for (int i = 0; i < 260; i++) begin
            rt = 8'hD0;
            if ($urandom_range(0, 3) == 0) begin
                rt = 8'($urandom);
                if (rt == 8'hD0) rt = 8'hD7;
            end
            do_req(16'($urandom), ($urandom_range(0, 15) == 0), rt, $urandom_range(0, 10),
                   ($urandom_range(0, 3) == 0), tid_m ^ 8'($urandom_range(1, 255)),
                   $urandom_range(0, 4));
        end

        // Reset while waiting for a response
        wait_ready();
        b0 = beats_seen;
        exp_beat_q.push_back(exp_tdata(tid_m, 16'hBEEF));
        exp_stall_q.push_back(0);
        m_axis_ireq_tready = 1'b1;
        db_req_valid = 1'b1;
        db_req_info  = 16'hBEEF;
        tick();
        db_req_valid = 1'b0;
        wait_beat(b0);
        repeat (3) tick();
        e0 = events_seen;
        areset = 1'b1;
        tick();
        check64("midrst_req_ready", 64'(db_req_ready), 64'd0);
        check64("midrst_ireq_tvalid", 64'(m_axis_ireq_tvalid), 64'd0);
        check64("midrst_busy", 64'(db_busy), 64'd0);
        tick();
        areset = 1'b0;
        tick();
        check64("midrst_release_ready", 64'(db_req_ready), 64'd1);
        check64("midrst_release_tready", 64'(s_axis_iresp_tready), 64'd1);
        check64("midrst_no_pulse", 64'(events_seen), 64'(e0));
        tid_m = 8'h00;

        // A response while idle is dropped
        send_resp(8'h00, 8'hD0);
        repeat (3) tick();
        check64("idle_resp_dropped", 64'(events_seen), 64'(e0));

        // Stray tid 07 while waiting on tid 0, then the real response
        do_req(16'h7777, 1'b0, 8'hD0, 1, 1'b1, 8'h07, 0);
        // Follow-up proves tid advanced to 1 after reset
        do_req(16'h4321, 1'b0, 8'hD0, 0, 1'b0, 8'h00, 2);

        repeat (5) tick();
        check64("beat_queue_drained", 64'(exp_beat_q.size()), 64'd0);
        check64("event_queue_drained", 64'(exp_evt_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/db_tx_engine.md
DB_TX_ENGINE -- requirements
Module: db_tx_engine

Interface
REQ-001 SHALL have parameter C_SRIO_DEV_ID, default 16'hF201, local device ID placed in ireq tuser[31:16].
REQ-002 SHALL have parameter C_SRIO_DEST_ID, default 16'h7801, target device ID placed in ireq tuser[15:0].
REQ-003 SHALL have parameter C_PRIO, default 2'b01, request priority placed in tdata[46:45].
REQ-004 SHALL have parameter C_TIMEOUT, default 32'd1000000, response-wait limit in aclk cycles, legal range >=2.
REQ-005 SHALL have parameter C_MAX_RETRY, default 3, resends after timeout, used only when DB_TX_RETRY_EN is defined.
REQ-006 SHALL have port aclk, input, 1, sole clock; one clock; all logic on its rising edge.
REQ-007 SHALL have port areset, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port db_req_valid, input, 1, doorbell send request.
REQ-009 SHALL have port db_req_ready, output, 1, request accepted when high with db_req_valid.
REQ-010 SHALL have port db_req_info, input, 16, doorbell info field.
REQ-011 SHALL have port db_done, output, 1, single-cycle pulse on successful response.
REQ-012 SHALL have port db_err, output, 1, single-cycle pulse on error response or final timeout.
REQ-013 SHALL have port db_busy, output, 1, high while not in IDLE.
REQ-014 SHALL have ports m_axis_ireq_tvalid/tready/tdata[63:0]/tkeep[7:0]/tlast/tuser[31:0], out/in/out/out/out/out, AXI4-Stream HELLO request master.
REQ-015 SHALL have ports s_axis_iresp_tvalid/tready/tdata[63:0]/tkeep[7:0]/tlast/tuser[31:0], in/out/in/in/in/in, AXI4-Stream HELLO response slave.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT; db_req_ready=1 only in IDLE.
REQ-017 SHALL, on db_req_valid&db_req_ready at cycle N, latch info, enter SEND, and assert ireq_tvalid at N+1.
REQ-018 SHALL drive ireq tdata = {tid[7:0], 8'hA0, 1'b0, C_PRIO, 1'b0, 12'b0, info[15:0], 16'b0}, tkeep=8'hFF, tlast=1, tuser={C_SRIO_DEV_ID, C_SRIO_DEST_ID}, all held stable while tvalid&!tready.
REQ-019 SHALL, on ireq handshake, deassert tvalid next cycle, clear timeout counter, enter WAIT.
REQ-020 SHALL hold s_axis_iresp_tready=1 in every state after reset; responses outside WAIT or with tdata[63:56]!=tid are consumed and dropped.
REQ-021 SHALL, in WAIT, on iresp handshake with tdata[63:56]==tid: tdata[55:48]==8'hD0 -> db_done pulse next cycle; any other value -> db_err pulse next cycle; both return to IDLE.
REQ-022 SHALL increment tid (8-bit, wraps 8'hFF->8'h00) once per completed request (done or err), never per retry.
REQ-023 SHALL count WAIT cycles; timeout when counter reaches C_TIMEOUT-1 without a matching response.
REQ-024 SHALL give a matching response priority over timeout in the same cycle.
REQ-025 SHALL never assert db_done and db_err in the same cycle.

Reset
REQ-026 SHALL, while areset=1 at a rising edge, set state IDLE, tid=0, counters 0, db_done=db_err=db_busy=0, ireq tvalid/tdata/tkeep/tlast/tuser=0, iresp tready=0, db_req_ready=0; reset mid-transfer abandons the request with no pulse.
REQ-027 SHALL drive db_req_ready=1 and iresp tready=1 from the first cycle after areset deasserts.

Configuration
REQ-028 SHALL, with macro DB_TX_RETRY_EN defined, on timeout resend the same tid/info via SEND while retries used < C_MAX_RETRY, and pulse db_err after the final timeout.
REQ-029 SHALL, without DB_TX_RETRY_EN, pulse db_err on first timeout and return to IDLE; no retry counter is synthesized.

Verification
REQ-030 SHALL cover: req info=16'h1234, ireq_tready=1, response tid=0 type D0 after 5 cycles -> ireq tdata=64'h00A0_2000_1234_0000, db_done one pulse, tid=1.
REQ-031 SHALL cover: ireq_tready low 4 cycles -> tvalid and tdata stable 4 cycles, single beat sent.
REQ-032 SHALL cover: response tid=8'h07 while waiting on tid 0, then tid 0 type D0 -> first dropped, db_done once.
REQ-033 SHALL cover: C_TIMEOUT=16, no response, retry enabled, C_MAX_RETRY=3 -> 4 identical ireq beats, db_err once; retry disabled -> 1 beat, db_err once.
REQ-034 SHALL cover: response type 8'hD7 tid match -> db_err pulse, no db_done; 256 requests -> tid wraps to 0.
REQ-035 SHALL cover: areset during WAIT -> no pulse, tid=0, db_req_ready=1 the cycle after release.
